// File: rtl/lcd1602_row_driver.sv
// -----------------------------------------------------------------------------
// lcd1602_row_driver
//
// Drives an HD44780-compatible 16x2 character LCD over its 8-bit parallel bus
// from two 128-bit ASCII row buffers. After reset it waits for the panel to
// power up, runs the init command sequence once, then writes both lines.
// From then on it re-writes the whole display whenever either row buffer
// differs from the snapshot that was last displayed.
//
// Ports
//   clk        in   system clock
//   nrst       in   asynchronous active-low reset
//   row1       in   [127:0] line 1 characters, [127:120] = column 0
//   row2       in   [127:0] line 2 characters, same ordering
//   lcd_en     out  LCD enable strobe
//   lcd_rs     out  register select (0 = command, 1 = data)
//   lcd_rw     out  read/write, tied low (write-only)
//   lcd_data   out  [7:0] LCD data bus
//   lcd_on     out  high once the init sequence has completed
//   busy       out  high in every state except IDLE
//   frame_done out  one-cycle pulse after the last line-2 character's delay
//   dbg_state  out  [4:0] {state, phase} of the sequencer, for observation
//
// Bus protocol (there is no valid/ready handshake on this block):
//   every LCD transfer is SETUP (1 cycle, rs/data change, en low), EHIGH
//   (E_PULSE cycles, en high), WAIT (D cycles, en low). rs/data only change
//   on entry to SETUP, so they are stable for the whole time en is high.
//   row1/row2 are level inputs sampled continuously; no handshake with the
//   front-end is needed because a snapshot is taken at the start of a frame.
// -----------------------------------------------------------------------------
module lcd1602_row_driver #(
    parameter int POWERUP_CYCLES = 2000000,
    parameter int E_PULSE        = 25,
    parameter int CMD_DELAY      = 2500,
    parameter int CLR_DELAY      = 100000
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [127:0] row1,
    input  logic [127:0] row2,
    output logic         lcd_en,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_data,
    output logic         lcd_on,
    output logic         busy,
    output logic         frame_done,
    output logic [4:0]   dbg_state
);

    // Top-level sequencer states.
    localparam logic [2:0] S_POWERUP = 3'd0;
    localparam logic [2:0] S_INIT    = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_ADDR1   = 3'd3;
    localparam logic [2:0] S_LINE1   = 3'd4;
    localparam logic [2:0] S_ADDR2   = 3'd5;
    localparam logic [2:0] S_LINE2   = 3'd6;
    localparam logic [2:0] S_IDLE    = 3'd7;

    // Phases of one bus transfer, used by INIT/ADDR1/LINE1/ADDR2/LINE2.
    localparam logic [1:0] P_SETUP = 2'd0;
    localparam logic [1:0] P_EHIGH = 2'd1;
    localparam logic [1:0] P_WAIT  = 2'd2;

    // LCD commands.
    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_LINE1 = 8'h80;
    localparam logic [7:0] CMD_LINE2 = 8'hC0;

    // Delay reload values for the shared down-counter.
    localparam logic [23:0] POWERUP_C = 24'(POWERUP_CYCLES);
    localparam logic [23:0] E_PULSE_C = 24'(E_PULSE);
    localparam logic [23:0] CMD_C     = 24'(CMD_DELAY);
    localparam logic [23:0] CLR_C     = 24'(CLR_DELAY);

    // Init command table: 8-bit/2-line, display on, clear, entry mode.
    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        logic [7:0] c;
        case (i)
            2'd0:    c = 8'h38;
            2'd1:    c = 8'h0C;
            2'd2:    c = CMD_CLEAR;
            default: c = 8'h06;
        endcase
        return c;
    endfunction

    // Character at column i of a row buffer; column 0 is the top byte.
    function automatic logic [7:0] pick(input logic [127:0] r,
                                        input logic [3:0]   i);
        logic [6:0] base;
        base = {4'd15 - i, 3'b000};
        return r[base +: 8];
    endfunction

    // Flops.
    logic [2:0]   state_q,    state_d;
    logic [1:0]   phase_q,    phase_d;
    logic [23:0]  cnt_q,      cnt_d;
    logic [3:0]   idx_q,      idx_d;
    logic [1:0]   init_idx_q, init_idx_d;
    logic [127:0] shadow1_q,  shadow1_d;
    logic [127:0] shadow2_q,  shadow2_d;
    logic         diff_q,     diff_d;
    logic         en_q,       en_d;
    logic         rs_q,       rs_d;
    logic [7:0]   data_q,     data_d;
    logic         on_q,       on_d;
    logic         fd_q,       fd_d;

    // Helpers from the transfer engine to the sequencing logic.
    logic         cnt_last;
    logic [23:0]  cnt_dec;
    logic         is_xfer_state;
    logic         xfer_done;

    assign cnt_last      = (cnt_q == 24'd1);
    assign cnt_dec       = cnt_q - 24'd1;
    assign is_xfer_state = (state_q == S_INIT)  || (state_q == S_ADDR1) ||
                           (state_q == S_LINE1) || (state_q == S_ADDR2) ||
                           (state_q == S_LINE2);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        init_idx_d = init_idx_q;
        shadow1_d  = shadow1_q;
        shadow2_d  = shadow2_q;
        en_d       = en_q;
        rs_d       = rs_q;
        data_d     = data_q;
        on_d       = on_q;
        fd_d       = 1'b0;
        xfer_done  = 1'b0;

        // Registered compare: IDLE acts on the previous cycle's result, so a
        // row change seen in IDLE reaches LOAD two clock edges later.
        diff_d = ({row1, row2} != {shadow1_q, shadow2_q});

        // Transfer engine: walks SETUP -> EHIGH -> WAIT for the current byte.
        if (is_xfer_state) begin
            case (phase_q)
                P_SETUP: begin
                    phase_d = P_EHIGH;
                    en_d    = 1'b1;
                    cnt_d   = E_PULSE_C;
                end
                P_EHIGH: begin
                    if (cnt_last) begin
                        phase_d = P_WAIT;
                        en_d    = 1'b0;
                        // Only the clear command needs the long settle time.
                        cnt_d   = (!rs_q && data_q == CMD_CLEAR) ? CLR_C : CMD_C;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                P_WAIT: begin
                    if (cnt_last) begin
                        xfer_done = 1'b1;
                    end else begin
                        cnt_d = cnt_dec;
                    end
                end
                default: begin
                    phase_d = P_SETUP;
                end
            endcase
        end

        // Sequencing. Starting a new transfer means loading rs/data and
        // entering SETUP in the same step, so the bus changes only there.
        case (state_q)
            S_POWERUP: begin
                if (cnt_last) begin
                    state_d    = S_INIT;
                    phase_d    = P_SETUP;
                    init_idx_d = 2'd0;
                    rs_d       = 1'b0;
                    data_d     = init_cmd(2'd0);
                end else begin
                    cnt_d = cnt_dec;
                end
            end

            S_INIT: begin
                if (xfer_done) begin
                    if (init_idx_q == 2'd3) begin
                        on_d    = 1'b1;
                        state_d = S_LOAD;
                        phase_d = P_SETUP;
                        rs_d    = 1'b0;
                        data_d  = CMD_LINE1;
                    end else begin
                        init_idx_d = init_idx_q + 2'd1;
                        phase_d    = P_SETUP;
                        rs_d       = 1'b0;
                        data_d     = init_cmd(init_idx_q + 2'd1);
                    end
                end
            end

            // LOAD doubles as the SETUP cycle of the line-1 address command:
            // the bus already shows 0x80 with en low, so the next cycle goes
            // straight to EHIGH. This keeps every transfer at 1+E_PULSE+D.
            S_LOAD: begin
                shadow1_d = row1;
                shadow2_d = row2;
                idx_d     = 4'd0;
                state_d   = S_ADDR1;
                phase_d   = P_EHIGH;
                en_d      = 1'b1;
                cnt_d     = E_PULSE_C;
            end

            S_ADDR1: begin
                if (xfer_done) begin
                    state_d = S_LINE1;
                    phase_d = P_SETUP;
                    rs_d    = 1'b1;
                    data_d  = pick(shadow1_q, idx_q);
                end
            end

            S_LINE1: begin
                if (xfer_done) begin
                    phase_d = P_SETUP;
                    if (idx_q == 4'd15) begin
                        idx_d   = 4'd0;
                        state_d = S_ADDR2;
                        rs_d    = 1'b0;
                        data_d  = CMD_LINE2;
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        rs_d   = 1'b1;
                        data_d = pick(shadow1_q, idx_q + 4'd1);
                    end
                end
            end

            S_ADDR2: begin
                if (xfer_done) begin
                    state_d = S_LINE2;
                    phase_d = P_SETUP;
                    rs_d    = 1'b1;
                    data_d  = pick(shadow2_q, idx_q);
                end
            end

            S_LINE2: begin
                if (xfer_done) begin
                    phase_d = P_SETUP;
                    if (idx_q == 4'd15) begin
                        idx_d   = 4'd0;
                        state_d = S_IDLE;
                        fd_d    = 1'b1;
                    end else begin
                        idx_d  = idx_q + 4'd1;
                        rs_d   = 1'b1;
                        data_d = pick(shadow2_q, idx_q + 4'd1);
                    end
                end
            end

            // IDLE keeps rs/data at the last character sent; a refresh
            // presents the 0x80 address on the way into LOAD.
            S_IDLE: begin
                if (diff_q) begin
                    state_d = S_LOAD;
                    phase_d = P_SETUP;
                    rs_d    = 1'b0;
                    data_d  = CMD_LINE1;
                end
            end

            default: begin
                state_d = S_POWERUP;
                cnt_d   = POWERUP_C;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_POWERUP;
            phase_q    <= P_SETUP;
            cnt_q      <= POWERUP_C;
            idx_q      <= 4'd0;
            init_idx_q <= 2'd0;
            shadow1_q  <= 128'd0;
            shadow2_q  <= 128'd0;
            diff_q     <= 1'b0;
            en_q       <= 1'b0;
            rs_q       <= 1'b0;
            data_q     <= 8'h00;
            on_q       <= 1'b0;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            init_idx_q <= init_idx_d;
            shadow1_q  <= shadow1_d;
            shadow2_q  <= shadow2_d;
            diff_q     <= diff_d;
            en_q       <= en_d;
            rs_q       <= rs_d;
            data_q     <= data_d;
            on_q       <= on_d;
            fd_q       <= fd_d;
        end
    end

    assign lcd_en     = en_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = data_q;
    assign lcd_on     = on_q;
    assign frame_done = fd_q;
    assign busy       = (state_q != S_IDLE);
    assign dbg_state  = {state_q, phase_q};

endmodule

// File: tb/tb_lcd1602_row_driver.sv
// -----------------------------------------------------------------------------
// tb_lcd1602_row_driver
//
// Self-checking bench for lcd1602_row_driver with small delay parameters.
// The reference model turns the row strings the bench drives into the list
// of bytes a frame must carry, and derives rising-edge spacing of lcd_en from
// the transfer length 1 + E_PULSE + delay.
// -----------------------------------------------------------------------------
module tb_lcd1602_row_driver;

    localparam int PU = 20;
    localparam int EP = 2;
    localparam int CD = 4;
    localparam int CL = 10;

    // ---------------- clock / reset ----------------
    logic         clk  = 1'b0;
    logic         nrst = 1'b0;
    logic [127:0] row1;
    logic [127:0] row2;
    logic         lcd_en;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [7:0]   lcd_data;
    logic         lcd_on;
    logic         busy;
    logic         frame_done;
    logic [4:0]   dbg_state;

    always #5 clk = ~clk;

    lcd1602_row_driver #(
        .POWERUP_CYCLES(PU),
        .E_PULSE       (EP),
        .CMD_DELAY     (CD),
        .CLR_DELAY     (CL)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .row1      (row1),
        .row2      (row2),
        .lcd_en    (lcd_en),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data),
        .lcd_on    (lcd_on),
        .busy      (busy),
        .frame_done(frame_done),
        .dbg_state (dbg_state)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- bus monitor ----------------
    int         cyc = 0;
    logic [8:0] obs_b_q[$];
    int         obs_c_q[$];
    int         fd_count   = 0;
    int         fd_cyc     = 0;
    int         proto_viol = 0;
    int         rw_viol    = 0;
    logic       en_prev    = 1'b0;
    logic [8:0] rsd_prev   = 9'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (lcd_rw !== 1'b0) rw_viol <= rw_viol + 1;
        if (lcd_en && en_prev && ({lcd_rs, lcd_data} != rsd_prev))
            proto_viol <= proto_viol + 1;
        if (lcd_en && !en_prev) begin
            obs_b_q.push_back({lcd_rs, lcd_data});
            obs_c_q.push_back(cyc);
        end
        if (frame_done) begin
            fd_count <= fd_count + 1;
            fd_cyc   <= cyc;
        end
        en_prev  <= lcd_en;
        rsd_prev <= {lcd_rs, lcd_data};
    end

    // ---------------- driver helpers ----------------
    task automatic get_xfer(output logic [8:0] b, output int c, output bit ok);
        int waited = 0;
        while (obs_b_q.size() == 0 && waited < 3000) begin
            @(posedge clk);
            waited++;
        end
        if (obs_b_q.size() == 0) begin
            ok = 1'b0;
            b  = 9'h0;
            c  = 0;
        end else begin
            ok = 1'b1;
            b  = obs_b_q.pop_front();
            c  = obs_c_q.pop_front();
        end
    endtask

    function automatic logic [127:0] rand_row();
        logic [127:0] r;
        for (int col = 0; col < 16; col++) begin
            if ($urandom_range(0, 3) == 0) r[8*(15-col) +: 8] = 8'hA0;
            else r[8*(15-col) +: 8] = 8'($urandom_range(32, 126));
        end
        return r;
    endfunction

    // Scoreboard for one frame: the model lists the bytes the frame must
    // carry (optional init, line-1 address, 16 chars, line-2 address, 16
    // chars) and the spacing of successive lcd_en rising edges.
    task automatic check_frame(input string tag, input logic [127:0] r1,
                               input logic [127:0] r2, input bit with_init,
                               input int change_at, input logic [127:0] new_r2,
                               output int first_c);
        logic [8:0] exp_q[$];
        logic [8:0] b;
        logic [8:0] prev_b;
        int         c;
        int         prev_c;
        int         fd_before;
        int         waited;
        bit         ok;

        fd_before = fd_count;
        first_c   = -1;
        if (with_init) begin
            exp_q.push_back(9'h038);
            exp_q.push_back(9'h00C);
            exp_q.push_back(9'h001);
            exp_q.push_back(9'h006);
        end
        exp_q.push_back(9'h080);
        for (int col = 0; col < 16; col++) exp_q.push_back({1'b1, r1[8*(15-col) +: 8]});
        exp_q.push_back(9'h0C0);
        for (int col = 0; col < 16; col++) exp_q.push_back({1'b1, r2[8*(15-col) +: 8]});

        prev_b = 9'h0;
        prev_c = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            get_xfer(b, c, ok);
            if (!ok) begin
                check($sformatf("%s_xfer_timeout%0d", tag, i), 32'd0, 32'd1);
                return;
            end
            check($sformatf("%s_x%0d", tag, i), 32'(b), 32'(exp_q[i]));
            if (i == 0) first_c = c;
            else check($sformatf("%s_gap%0d", tag, i), 32'(c - prev_c),
                       32'(1 + EP + ((prev_b == 9'h001) ? CL : CD)));
            prev_b = exp_q[i];
            prev_c = c;
            if (i == change_at) row2 = new_r2;
        end

        waited = 0;
        while (fd_count == fd_before && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        if (fd_count == fd_before) begin
            check($sformatf("%s_fd_timeout", tag), 32'd0, 32'd1);
            return;
        end
        // frame_done follows the last rising edge by E_PULSE + CMD_DELAY.
        check($sformatf("%s_fd_lat", tag), 32'(fd_cyc - prev_c), 32'(EP + CD));
        repeat (2) @(posedge clk);
        check($sformatf("%s_fd_width", tag), 32'(fd_count - fd_before), 32'd1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    logic [127:0] blank_row;
    logic [127:0] r12;
    logic [127:0] r42;
    logic [127:0] old_r2;
    logic [127:0] nr1;
    int           rel_cyc;
    int           first_c;
    int           fd1;
    int           bad;
    int           waited;

    initial begin
        blank_row = {16{8'hA0}};
        r12       = {8'h31, 8'h32, 8'h2B, {13{8'hA0}}};
        r42       = {{9{8'hA0}}, 8'h3D, 8'h30, 8'h30, 8'h30, 8'h30, 8'h34, 8'h32};
        row1      = blank_row;
        row2      = blank_row;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_en",   32'(lcd_en),     32'd0);
        check("rst_rs",   32'(lcd_rs),     32'd0);
        check("rst_rw",   32'(lcd_rw),     32'd0);
        check("rst_data", 32'(lcd_data),   32'h00);
        check("rst_on",   32'(lcd_on),     32'd0);
        check("rst_fd",   32'(frame_done), 32'd0);
        check("rst_busy", 32'(busy),       32'd1);

        // 1: power-up, init, first frame of blanks.
        @(negedge clk);
        nrst    = 1'b1;
        rel_cyc = cyc;
        check_frame("init", blank_row, blank_row, 1'b1, -1, 128'd0, first_c);
        check("init_first_edge", 32'(first_c - rel_cyc), 32'(PU + 1));
        check("init_lcd_on", 32'(lcd_on), 32'd1);
        check("init_idle", 32'(busy), 32'd0);

        // 2: row1 change in IDLE; busy rises two edges later, no init.
        @(negedge clk);
        row1 = r12;
        @(posedge clk); #1;
        check("busy_lat1", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("busy_lat2", 32'(busy), 32'd1);
        check_frame("ref12", r12, blank_row, 1'b0, -1, 128'd0, first_c);
        check("ref12_lcd_on", 32'(lcd_on), 32'd1);

        // 3: row2 changes mid-LINE1; old frame completes, follow-up frame
        //    carries the new row2 and starts right after frame_done.
        @(negedge clk);
        nr1    = rand_row();
        if (nr1 == row1) nr1[7:0] = ~nr1[7:0];
        row1   = nr1;
        old_r2 = row2;
        check_frame("mid_a", nr1, old_r2, 1'b0, 5, r42, first_c);
        fd1 = fd_cyc;
        check_frame("mid_b", nr1, r42, 1'b0, -1, 128'd0, first_c);
        check("mid_b_start", 32'(first_c - fd1), 32'd2);

        // Randomized refreshes, including unchanged rows (no refresh).
        for (int it = 0; it < 5; it++) begin
            @(negedge clk);
            if (it == 2) begin
                row1 = row1;
                bad  = 0;
                repeat (40) begin
                    @(posedge clk); #1;
                    if (busy || lcd_en) bad++;
                end
                check("nochange_quiet", 32'(bad), 32'd0);
            end else begin
                nr1 = rand_row();
                if (nr1 == row1) nr1[7:0] = ~nr1[7:0];
                row1 = nr1;
                if (it % 2 == 1) row2 = rand_row();
                check_frame($sformatf("rnd%0d", it), row1, row2, 1'b0, -1,
                            128'd0, first_c);
            end
        end
        check("no_stray_xfers", 32'(obs_b_q.size()), 32'd0);

        // 5: stable rows for 500 cycles.
        bad = 0;
        repeat (500) begin
            @(posedge clk); #1;
            if (lcd_en || busy || frame_done || lcd_data !== row2[7:0]) bad++;
        end
        check("idle_quiet", 32'(bad), 32'd0);
        check("idle_data", 32'(lcd_data), 32'(row2[7:0]));
        check("idle_rs", 32'(lcd_rs), 32'd1);

        // 4: asynchronous reset during LINE1, then full init again.
        @(negedge clk);
        nr1 = rand_row();
        if (nr1 == row1) nr1[7:0] = ~nr1[7:0];
        row1   = nr1;
        waited = 0;
        while (obs_b_q.size() < 4 && waited < 2000) begin
            @(posedge clk);
            waited++;
        end
        check("rst_mid_reached", 32'(obs_b_q.size() >= 4), 32'd1);
        @(posedge clk);
        #3 nrst = 1'b0;
        #1;
        check("arst_en",   32'(lcd_en),     32'd0);
        check("arst_rs",   32'(lcd_rs),     32'd0);
        check("arst_data", 32'(lcd_data),   32'h00);
        check("arst_on",   32'(lcd_on),     32'd0);
        check("arst_fd",   32'(frame_done), 32'd0);
        check("arst_busy", 32'(busy),       32'd1);
        repeat (3) @(posedge clk);
        obs_b_q.delete();
        obs_c_q.delete();
        @(negedge clk);
        nrst    = 1'b1;
        rel_cyc = cyc;
        check_frame("reinit", row1, row2, 1'b1, -1, 128'd0, first_c);
        check("reinit_first_edge", 32'(first_c - rel_cyc), 32'(PU + 1));
        check("reinit_lcd_on", 32'(lcd_on), 32'd1);

        // 6: bus invariants over the whole run.
        check("rw_always_low", 32'(rw_viol), 32'd0);
        check("bus_stable_en_high", 32'(proto_viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
